ysyx_220053_divu: RTL

//   Iterative radix-2 restoring integer divider; inverse of the Booth multiplier in the EXU.

---
 rtl/ysyx_220053_div_pkg.sv | 16 +
 rtl/ysyx_220053_div_step.sv | 32 +++
 rtl/ysyx_220053_divu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ysyx_220053_div_pkg.sv
// rtl/ysyx_220053_div_pkg.sv - shared constants for the iterative restoring divider
// Contents: operand width, iteration counter width, FSM state encoding,
//           divide-by-zero quotient value.
package ysyx_220053_div_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    // Plain encoded constants keep the state bits stable for older tooling.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUO = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/ysyx_220053_div_step.sv
// rtl/ysyx_220053_div_step.sv - one combinational radix-2 restoring division step
// Ports:
//   rem         in   WIDTH  partial remainder (always < divisor_mag)
//   quo         in   WIDTH  partial quotient; upper bits still hold unshifted dividend
//   divisor_mag in   WIDTH  divisor magnitude
//   rem_next    out  WIDTH  partial remainder after this step
//   quo_next    out  WIDTH  partial quotient after this step
module ysyx_220053_div_step
    import ysyx_220053_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // {rem, quo} shifted left by one; the extra top bit keeps the trial exact.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor_mag};

    // When the trial subtraction fits, the result is below divisor_mag and
    // therefore representable in WIDTH bits.
    assign rem_next = fits ? WIDTH'(shifted - {1'b0, divisor_mag}) : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/ysyx_220053_divu.sv
// rtl/ysyx_220053_divu.sv - iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   dividend    in   WIDTH  dividend, sampled on accept
//   divisor     in   WIDTH  divisor, sampled on accept
//   div_signed  in   1      two's-complement operands, sampled on accept
//   div_valid   in   1      request valid
//   div_ready   out  1      idle, request can be accepted
//   flush       in   1      abort in-flight op / block accept
//   out_valid   out  1      one-cycle completion pulse
//   quotient    out  WIDTH  quotient, held until next completion
//   remainder   out  WIDTH  remainder, held until next completion
module ysyx_220053_divu
    import ysyx_220053_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_mag;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dsr_mag_c;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE) && !flush;
    assign accept    = div_ready && div_valid && !flush;

    assign dvd_neg   = div_signed && dividend[WIDTH-1];
    assign dsr_neg   = div_signed && divisor[WIDTH-1];
    assign dvd_mag_c = dvd_neg ? -dividend : dividend;
    assign dsr_mag_c = dsr_neg ? -divisor : divisor;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    ysyx_220053_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_q),
        .quo        (quo_q),
        .divisor_mag(dsr_mag),
        .rem_next   (rem_next),
        .quo_next   (quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            // Divide by zero skips the iteration entirely.
                            state     <= DONE;
                            quotient  <= DIV0_QUO;
                            remainder <= dividend;
                        end else begin
                            state   <= CALC;
                            cnt     <= '0;
                            rem_q   <= '0;
                            quo_q   <= dvd_mag_c;
                            dsr_mag <= dsr_mag_c;
                            neg_q   <= dvd_neg ^ dsr_neg;
                            neg_r   <= dvd_neg;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + 1'b1;
                        if (last_step) begin
                            // Sign fixup on the final step's outputs; the
                            // -2^(W-1)/-1 case yields 2^(W-1) unnegated, which
                            // is already the required wrapped result.
                            state     <= DONE;
                            quotient  <= neg_q ? -quo_next : quo_next;
                            remainder <= neg_r ? -rem_next : rem_next;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
